// File: rtl/instr_fetch_queue.sv
// Fetch queue: issues in-order imem requests for PC, tags responses with their PC and buffers them for decode.
// Optional FETCH_STATS_EN adds saturating StatFetched/StatDropped counters.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        PCValid,
  output logic        PCReady,
  input  logic        Flush,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        InstrValid,
  input  logic        DecReady,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] InstrPCPlus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] StatFetched,
  output logic [31:0] StatDropped
`endif
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  // state | meaning
  // RUN   | normal fetch; requests issued while credit remains
  // DRAIN | flushed with fetches outstanding; their responses are discarded
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;
  state_e state_q, state_d;

  logic [31:0]     q_instr_q [DEPTH];
  logic [31:0]     q_pc_q    [DEPTH];
  logic [31:0]     tag_q     [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CntW-1:0] count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [CntW:0]   occupancy;
  logic            credit_ok, req, grant, drop, push, pop;

  // Credit counts in-flight fetches so a response always finds a free slot.
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
  assign credit_ok = occupancy < (CntW+1)'(DEPTH);
  assign grant     = req & IMemGnt;
  assign drop      = IMemRValid & (Flush | (discard_q != '0));
  assign push      = IMemRValid & ~drop;
  assign pop       = InstrValid & DecReady & ~Flush;

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (discard_d != '0) state_d = DRAIN;
  end

  always_comb begin
    req = 1'b0;
    if (state_q == RUN) req = PCValid & ~Flush & credit_ok;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    count_d    = count_q + CntW'(push) - CntW'(pop);
    tag_wr_d   = tag_wr_q + PtrW'(grant);
    tag_rd_d   = tag_rd_q + PtrW'(IMemRValid);
    inflight_d = inflight_q + CntW'(grant) - CntW'(IMemRValid);
    discard_d  = discard_q;
    if (Flush) begin
      count_d   = '0;
      wr_ptr_d  = rd_ptr_q;
      discard_d = inflight_q - CntW'(IMemRValid);
    end else if (IMemRValid && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Storage needs no reset: outputs are gated by InstrValid.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_instr_q[wr_ptr_q] <= IMemRData;
      q_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
    end
    if (grant) tag_q[tag_wr_q] <= PC;
  end

  assign IMemReq      = req;
  assign IMemAddr     = PC;
  assign PCReady      = grant;
  assign InstrValid   = (count_q != '0);
  assign Instr        = InstrValid ? q_instr_q[rd_ptr_q] : 32'h0;
  assign InstrPC      = InstrValid ? q_pc_q[rd_ptr_q] : 32'h0;
  assign InstrPCPlus4 = InstrValid ? (q_pc_q[rd_ptr_q] + 32'd4) : 32'h0;

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, dropped_q, drop_n;
  logic [32:0] fetched_sum, dropped_sum;

  // Entries cleared by a flush count as dropped alongside discarded responses.
  assign drop_n      = 32'(drop) + (Flush ? 32'(count_q) : 32'd0);
  assign fetched_sum = {1'b0, fetched_q} + 33'(push);
  assign dropped_sum = {1'b0, dropped_q} + {1'b0, drop_n};

  always_ff @(posedge CLK) begin
    if (Reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      dropped_q <= dropped_sum[32] ? 32'hFFFF_FFFF : dropped_sum[31:0];
    end
  end

  assign StatFetched = fetched_q;
  assign StatDropped = dropped_q;
`endif

endmodule
